// File: rtl/alu_stim_pkg.sv
// Shared types and widths for the ALU stimulus driver.
package alu_stim_pkg;

  localparam int unsigned ALU_OP_W  = 3;
  localparam int unsigned ALU_IN_W  = 8;
  localparam int unsigned ALU_RES_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    EMIT,
    DONE
  } state_e;

  // One-bit left rotate used by the optional result signature.
  function automatic logic [ALU_RES_W-1:0] rotl1(input logic [ALU_RES_W-1:0] v);
    return {v[ALU_RES_W-2:0], v[ALU_RES_W-1]};
  endfunction

endpackage

// File: rtl/alu_stim_driver_if.sv
// Record stream from the ALU stimulus driver to its display consumer.
interface alu_stim_driver_if;
  import alu_stim_pkg::*;

  logic                 out_valid;
  logic                 out_ready;
  logic [ALU_OP_W-1:0]  out_op;
  logic [ALU_IN_W-1:0]  out_num1;
  logic [ALU_RES_W-1:0] out_result;

  modport master (
    output out_valid,
    output out_op,
    output out_num1,
    output out_result,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_op,
    input  out_num1,
    input  out_result,
    output out_ready
  );

endinterface

// File: rtl/alu_stim_sig.sv
// Rotate-XOR signature over every accepted result record.
// Built only when ALU_STIM_SIG_EN is defined.
`ifdef ALU_STIM_SIG_EN
module alu_stim_sig
  import alu_stim_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 upd,
  input  logic [ALU_RES_W-1:0] data,
  output logic [ALU_RES_W-1:0] sig
);

  logic [ALU_RES_W-1:0] sig_q, sig_d;

  // Clear on run start, fold in each accepted record.
  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (upd) begin
      sig_d = rotl1(sig_q) ^ data;
    end
  end

  // Signature register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule
`endif

// File: rtl/alu_stim_driver.sv
// Hardware stimulus driver for the combinational ALU: sweeps opcodes and
// operands, waits for the result to settle, captures it and streams records.
// Optional result signature output enabled by macro ALU_STIM_SIG_EN.
module alu_stim_driver
  import alu_stim_pkg::*;
#(
  parameter logic [ALU_OP_W-1:0] OP_FIRST      = 3'd0,
  parameter logic [ALU_OP_W-1:0] OP_LAST       = 3'd5,
  parameter int unsigned         SETTLE_CYCLES = 2,
  parameter int unsigned         NUM_PASSES    = 4,
  parameter logic [ALU_IN_W-1:0] STEP          = 8'd1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ALU_IN_W-1:0]  seed,
  output logic [ALU_OP_W-1:0]  op,
  output logic [ALU_IN_W-1:0]  num1,
  input  logic [ALU_RES_W-1:0] result,
  output logic                 busy,
  output logic                 done,
`ifdef ALU_STIM_SIG_EN
  output logic [ALU_RES_W-1:0] sig,
`endif
  alu_stim_driver_if.master    out
);

  localparam logic [3:0] CntInit  = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] LastPass = 8'(NUM_PASSES - 1);

  state_e               state_q, state_d;
  logic [ALU_OP_W-1:0]  op_q, op_d;
  logic [ALU_IN_W-1:0]  num1_q, num1_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [7:0]           pass_q, pass_d;
  logic                 valid_q, valid_d;
  logic [ALU_OP_W-1:0]  out_op_q, out_op_d;
  logic [ALU_IN_W-1:0]  out_num1_q, out_num1_d;
  logic [ALU_RES_W-1:0] out_result_q, out_result_d;

  // Next-state and datapath updates; abort overrides everything else.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    num1_d       = num1_q;
    cnt_d        = cnt_q;
    pass_d       = pass_q;
    valid_d      = valid_q;
    out_op_d     = out_op_q;
    out_num1_d   = out_num1_q;
    out_result_d = out_result_q;
    if (abort) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_d    = OP_FIRST;
            num1_d  = seed;
            pass_d  = '0;
            cnt_d   = CntInit;
            state_d = SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_q == '0) begin
            state_d = CAPTURE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        CAPTURE: begin
          out_op_d     = op_q;
          out_num1_d   = num1_q;
          out_result_d = result;
          valid_d      = 1'b1;
          state_d      = EMIT;
        end
        EMIT: begin
          // valid is always high here, so ready alone completes the handshake.
          if (out.out_ready) begin
            valid_d = 1'b0;
            if (op_q == OP_LAST && pass_q == LastPass) begin
              state_d = DONE;
            end else begin
              if (op_q == OP_LAST) begin
                op_d   = OP_FIRST;
                pass_d = pass_q + 8'd1;
              end else begin
                op_d = op_q + 3'd1;
              end
              num1_d  = num1_q + STEP;
              cnt_d   = CntInit;
              state_d = SETTLE;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      op_q         <= '0;
      num1_q       <= '0;
      cnt_q        <= '0;
      pass_q       <= '0;
      valid_q      <= 1'b0;
      out_op_q     <= '0;
      out_num1_q   <= '0;
      out_result_q <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      num1_q       <= num1_d;
      cnt_q        <= cnt_d;
      pass_q       <= pass_d;
      valid_q      <= valid_d;
      out_op_q     <= out_op_d;
      out_num1_q   <= out_num1_d;
      out_result_q <= out_result_d;
    end
  end

  assign op             = op_q;
  assign num1           = num1_q;
  assign out.out_valid  = valid_q;
  assign out.out_op     = out_op_q;
  assign out.out_num1   = out_num1_q;
  assign out.out_result = out_result_q;
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE) && !abort;

`ifdef ALU_STIM_SIG_EN
  logic sig_clr, sig_upd;

  assign sig_clr = (state_q == IDLE) && start && !abort;
  assign sig_upd = (state_q == EMIT) && out.out_ready && !abort;

  alu_stim_sig u_sig (
    .clk  (clk),
    .rst  (rst),
    .clr  (sig_clr),
    .upd  (sig_upd),
    .data (out_result_q),
    .sig  (sig)
  );
`endif

endmodule

// File: tb/tb_alu_stim_driver.sv
// Directed/randomised bench for alu_stim_driver with a record-level model.
module tb_alu_stim_driver;
  import alu_stim_pkg::*;

  localparam int NP   = 2;
  localparam int NOPS = 6;
  localparam int NREC = NP * NOPS;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  seed  = 8'h00;
  logic [2:0]  op;
  logic [7:0]  num1;
  logic [31:0] result;
  logic        busy;
  logic        done;
`ifdef ALU_STIM_SIG_EN
  logic [31:0] sig;
`endif

  alu_stim_driver_if bus ();

  alu_stim_driver #(
    .OP_FIRST      (3'd0),
    .OP_LAST       (3'd5),
    .SETTLE_CYCLES (2),
    .NUM_PASSES    (NP),
    .STEP          (8'd1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .abort  (abort),
    .seed   (seed),
    .op     (op),
    .num1   (num1),
    .result (result),
    .busy   (busy),
    .done   (done),
`ifdef ALU_STIM_SIG_EN
    .sig    (sig),
`endif
    .out    (bus)
  );

  always #5 clk = ~clk;

  // Model ALU: combinational, every field depends on op/num1.
  function automatic logic [31:0] alu_f(input logic [2:0] o, input logic [7:0] n);
    return {8'hA5, n, 5'b0, o, n ^ {5'b0, o}};
  endfunction

  assign result = alu_f(op, num1);

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_op"}, 32'(op), 32'd0);
    chk({tag, "_num1"}, 32'(num1), 32'd0);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_out_op"}, 32'(bus.out_op), 32'd0);
    chk({tag, "_out_num1"}, 32'(bus.out_num1), 32'd0);
    chk({tag, "_out_res"}, bus.out_result, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
`ifdef ALU_STIM_SIG_EN
    chk({tag, "_sig"}, sig, 32'd0);
`endif
  endtask

  // One full run: expected records come from the sweep rules directly.
  task automatic run(input logic [7:0] sd, input int ready_pct, input int hold,
                     input bit mid_start);
    logic [2:0]  eo[$];
    logic [7:0]  en[$];
    logic [7:0]  n;
    logic [31:0] sig_m;
    logic [2:0]  po, pop;
    logic [7:0]  pn, pnum;
    logic [31:0] pr;
    logic        pv, rdy;
    int          k, dn, cyc, last_hs;
    bit          done_seen, rate_chk;
    n = sd;
    for (int p = 0; p < NP; p++) begin
      for (int o = 0; o < NOPS; o++) begin
        eo.push_back(3'(o));
        en.push_back(n);
        n = n + 8'd1;
      end
    end
    sig_m = 32'd0;
    k = 0; dn = 0; last_hs = 0; done_seen = 0; pv = 0;
    po = '0; pop = '0; pn = '0; pnum = '0; pr = '0;
    rate_chk = (ready_pct == 100) && (hold == 0);
    seed = sd;
    start = 1'b1;
    bus.out_ready = 1'b0;
    step();
    start = 1'b0;
    cyc = 1;
    chk("busy_after_start", 32'(busy), 32'd1);
    while (!done_seen && cyc < 2000) begin
      if (pv) begin
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_out_op", 32'(bus.out_op), 32'(po));
        chk("hold_out_num1", 32'(bus.out_num1), 32'(pn));
        chk("hold_out_res", bus.out_result, pr);
        chk("hold_alu_op", 32'(op), 32'(pop));
        chk("hold_alu_num1", 32'(num1), 32'(pnum));
      end
      if (bus.out_valid && hold > 0) begin
        rdy = 1'b0;
        hold--;
      end else begin
        rdy = ($urandom_range(99) < ready_pct);
      end
      bus.out_ready = rdy;
      if (bus.out_valid && rdy) begin
        if (k < NREC) begin
          chk("rec_op", 32'(bus.out_op), 32'(eo[k]));
          chk("rec_num1", 32'(bus.out_num1), 32'(en[k]));
          chk("rec_result", bus.out_result, alu_f(eo[k], en[k]));
        end else begin
          chk("extra_record", 32'(k), 32'(NREC - 1));
        end
        if (rate_chk) chk("rec_interval", 32'(cyc - last_hs), 32'd4);
        sig_m = {sig_m[30:0], sig_m[31]} ^ bus.out_result;
        last_hs = cyc;
        k++;
      end
      if (done) begin
        dn++;
        chk("done_after_last_hs", 32'(cyc), 32'(last_hs + 1));
        done_seen = 1;
      end
      pv   = bus.out_valid && !rdy;
      po   = bus.out_op;
      pn   = bus.out_num1;
      pr   = bus.out_result;
      pop  = op;
      pnum = num1;
      start = mid_start && (cyc == 21);
      step();
      cyc++;
    end
    start = 1'b0;
    bus.out_ready = 1'b0;
    if (!done_seen) chk("run_timeout", 32'(cyc), 32'd0);
    for (int i = 0; i < 6; i++) begin
      if (done) dn++;
      step();
    end
    chk("record_count", 32'(k), 32'(NREC));
    chk("done_count", 32'(dn), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
`ifdef ALU_STIM_SIG_EN
    chk("signature", sig, sig_m);
`endif
  endtask

  initial begin
    logic [7:0] s;
    int         w, dn;
    bus.out_ready = 1'b0;

    // Reset values.
    #2;
    chk_reset_vals("reset");
    @(negedge clk);
    rst = 1'b1;
    step();
    chk_reset_vals("post_reset");

    // Nominal run, ready held high, record every 4 cycles.
    run(8'($urandom), 100, 0, 0);
    // Backpressure on the first record.
    run(8'($urandom), 100, 10, 0);
    // Operand wraps past 8'hFF.
    run(8'hFE, 100, 0, 0);
    // Random ready, start pulsed while busy.
    run(8'($urandom), 60, 0, 1);

    // Abort in EMIT together with ready: record discarded, no done.
    s = 8'($urandom);
    seed = s;
    start = 1'b1;
    step();
    start = 1'b0;
    w = 0;
    while (!bus.out_valid && w < 20) begin
      step();
      w++;
    end
    chk("abort_reach_emit", 32'(bus.out_valid), 32'd1);
    abort = 1'b1;
    bus.out_ready = 1'b1;
    step();
    abort = 1'b0;
    bus.out_ready = 1'b0;
    chk("abort_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_op_hold", 32'(op), 32'd0);
    chk("abort_num1_hold", 32'(num1), 32'(s));
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) dn++;
      step();
    end
    chk("abort_no_done", 32'(dn), 32'd0);
    run(8'($urandom), 100, 0, 0);

    // Asynchronous reset in the middle of SETTLE.
    seed = 8'h5A;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("pre_rst_num1", 32'(num1), 32'h5A);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("after_rst_busy", 32'(busy), 32'd0);
    run(8'($urandom), 100, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
